// File: rtl/guess_pkg.sv
// Shared types and constants for the guessing-game round controller.
// Holds FSM state, compare result and the round-to-digit-count map.
package guess_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_WAIT,
    S_COMPARE,
    S_WIN,
    S_LOSE
  } gc_state_t;

  typedef enum logic [1:0] {
    LT,
    EQ,
    GT
  } cmp_t;

  // [2] = hundreds, [1] = tens, [0] = ones
  typedef logic [2:0][3:0] bcd3_t;

  localparam int ROUNDS_PER_LEVEL = 3;

  localparam logic [3:0] LVL1_LAST =
    4'(ROUNDS_PER_LEVEL);
  localparam logic [3:0] LVL2_LAST =
    4'(2 * ROUNDS_PER_LEVEL);

  function automatic logic [1:0] max_digit_of(
    input logic [3:0] rnd
  );
    logic [1:0] m;
    if (rnd == 4'd0)
      m = 2'd0;
    else if (rnd <= LVL1_LAST)
      m = 2'd1;
    else if (rnd <= LVL2_LAST)
      m = 2'd2;
    else
      m = 2'd3;
    return m;
  endfunction

endpackage

// File: rtl/bcd3_compare.sv
// Combinational three-digit BCD comparator.
// Also flags digits that are not legal BCD or not in play.
module bcd3_compare
  import guess_pkg::*;
(
  input  bcd3_t      guess,
  input  bcd3_t      target,
  input  logic [1:0] max_digit,
  output cmp_t       result,
  output logic       valid
);

  // Most significant differing digit decides.
  always_comb begin
    result = EQ;
    priority case (1'b1)
      guess[2] != target[2]:
        result = (guess[2] > target[2]) ? GT : LT;
      guess[1] != target[1]:
        result = (guess[1] > target[1]) ? GT : LT;
      guess[0] != target[0]:
        result = (guess[0] > target[0]) ? GT : LT;
      default:
        result = EQ;
    endcase
  end

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (guess[i] > 4'd9)
        valid = 1'b0;
      if (guess[i] != 4'd0 && 2'(i) >= max_digit)
        valid = 1'b0;
    end
  end

endmodule

// File: rtl/guess_checker.sv
// Round controller and guess evaluator for the guessing game.
// Sequences rounds, scores guesses and tracks attempts.
module guess_checker
  import guess_pkg::*;
#(
  parameter int MAX_TRIES  = 5,
  parameter int NUM_ROUNDS = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  input  logic [3:0] target_digit_1,
  input  logic [3:0] target_digit_2,
  input  logic [3:0] target_digit_3,
  output logic [3:0] round,
  output logic [1:0] Max_digit,
  output logic       too_high,
  output logic       too_low,
  output logic       correct,
  output logic       invalid,
  output logic [3:0] attempts,
  output logic       win,
  output logic       lose,
  output logic       ready
);

  localparam logic [3:0] TRIES_L  = 4'(MAX_TRIES);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  gc_state_t  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] max_digit_q, max_digit_d;
  logic [3:0] attempts_q, attempts_d;
  logic       high_q, high_d;
  logic       low_q, low_d;
  logic       correct_q, correct_d;
  logic       invalid_q, invalid_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  bcd3_t      guess_q, guess_d;

  bcd3_t      target;
  cmp_t       cmp;
  logic       guess_ok;
  logic [3:0] attempts_inc;

  assign target = {target_digit_3,
                   target_digit_2,
                   target_digit_1};

  assign attempts_inc = attempts_q + 4'd1;

  bcd3_compare u_cmp (
    .guess     (guess_q),
    .target    (target),
    .max_digit (max_digit_q),
    .result    (cmp),
    .valid     (guess_ok)
  );

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    pend_d      = pend_q;
    max_digit_d = max_digit_q;
    attempts_d  = attempts_q;
    high_d      = high_q;
    low_d       = low_q;
    correct_d   = correct_q;
    invalid_d   = invalid_q;
    win_d       = win_q;
    lose_d      = lose_q;
    guess_d     = guess_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pend_d  = 4'd1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        round_d     = pend_q;
        max_digit_d = max_digit_of(pend_q);
        attempts_d  = 4'd0;
        high_d      = 1'b0;
        low_d       = 1'b0;
        correct_d   = 1'b0;
        invalid_d   = 1'b0;
        state_d     = S_SETTLE;
      end

      // Target lookup registers the new round here.
      S_SETTLE: state_d = S_WAIT;

      S_WAIT: begin
        if (submit) begin
          guess_d = {guess_digit_3,
                     guess_digit_2,
                     guess_digit_1};
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        high_d    = 1'b0;
        low_d     = 1'b0;
        correct_d = 1'b0;
        if (!guess_ok) begin
          invalid_d = 1'b1;
          state_d   = S_WAIT;
        end else begin
          invalid_d  = 1'b0;
          attempts_d = attempts_inc;
          unique case (cmp)
            GT:      high_d    = 1'b1;
            LT:      low_d     = 1'b1;
            default: correct_d = 1'b1;
          endcase
          if (cmp == EQ) begin
            if (round_q < LAST_RND) begin
              pend_d  = round_q + 4'd1;
              state_d = S_LOAD;
            end else begin
              win_d   = 1'b1;
              state_d = S_WIN;
            end
          end else if (attempts_inc == TRIES_L) begin
            lose_d  = 1'b1;
            state_d = S_LOSE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (start) begin
          win_d   = 1'b0;
          lose_d  = 1'b0;
          pend_d  = 4'd1;
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      pend_q      <= 4'd0;
      max_digit_q <= 2'd0;
      attempts_q  <= 4'd0;
      high_q      <= 1'b0;
      low_q       <= 1'b0;
      correct_q   <= 1'b0;
      invalid_q   <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      guess_q     <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      pend_q      <= pend_d;
      max_digit_q <= max_digit_d;
      attempts_q  <= attempts_d;
      high_q      <= high_d;
      low_q       <= low_d;
      correct_q   <= correct_d;
      invalid_q   <= invalid_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      guess_q     <= guess_d;
    end
  end

  assign round     = round_q;
  assign Max_digit = max_digit_q;
  assign too_high  = high_q;
  assign too_low   = low_q;
  assign correct   = correct_q;
  assign invalid   = invalid_q;
  assign attempts  = attempts_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign ready     = (state_q == S_WAIT);

endmodule

// File: tb/tb_guess_checker.sv
// Scoreboard bench for guess_checker.
// Directed guesses queue results; a monitor scores each evaluation.
module tb_guess_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, submit;
  logic [3:0] gd1, gd2, gd3;
  logic [3:0] td1, td2, td3;
  logic [3:0] round;
  logic [1:0] Max_digit;
  logic       too_high, too_low, correct, invalid;
  logic [3:0] attempts;
  logic       win, lose, ready;

  always #5 clk = ~clk;

  guess_checker #(
    .MAX_TRIES  (5),
    .NUM_ROUNDS (9)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .submit         (submit),
    .guess_digit_1  (gd1),
    .guess_digit_2  (gd2),
    .guess_digit_3  (gd3),
    .target_digit_1 (td1),
    .target_digit_2 (td2),
    .target_digit_3 (td3),
    .round          (round),
    .Max_digit      (Max_digit),
    .too_high       (too_high),
    .too_low        (too_low),
    .correct        (correct),
    .invalid        (invalid),
    .attempts       (attempts),
    .win            (win),
    .lose           (lose),
    .ready          (ready)
  );

  function automatic logic [11:0] lut(input logic [3:0] r);
    logic [11:0] v;
    case (r)
      4'd1:    v = 12'h002;
      4'd2:    v = 12'h005;
      4'd3:    v = 12'h009;
      4'd4:    v = 12'h057;
      4'd5:    v = 12'h012;
      4'd6:    v = 12'h099;
      4'd7:    v = 12'h123;
      4'd8:    v = 12'h456;
      4'd9:    v = 12'h999;
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  logic [11:0] tgt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tgt <= 12'h000;
    else        tgt <= lut(round);
  assign td3 = tgt[11:8];
  assign td2 = tgt[7:4];
  assign td1 = tgt[3:0];

  // flags = {too_high, too_low, correct, invalid}, wl = {win, lose}
  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] att;
    logic [1:0] wl;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t ex(input logic [3:0] f,
                              input logic [3:0] a,
                              input logic [1:0] wl);
    exp_t e;
    e.flags = f;
    e.att   = a;
    e.wl    = wl;
    return e;
  endfunction

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: an accepted submit yields a result one edge later.
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && ready && submit) begin
        @(posedge clk);
        @(posedge clk); #1;
        if (rst_n) begin
          a = ex({too_high, too_low, correct, invalid},
                 attempts, {win, lose});
          n_chk++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %h, none queued", a);
          end else begin
            e = expq.pop_front();
            if (a !== e) begin
              n_fail++;
              $display("FAIL sb_result: got %h, expected %h",
                       a, e);
            end
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_ready"}, int'(ready), 1);
  endtask

  task automatic guess(input logic [3:0] h, t, o,
                       input exp_t e, input bit push);
    wait_ready("guess");
    gd3 = h; gd2 = t; gd1 = o;
    submit = 1'b1;
    if (push) expq.push_back(e);
    @(negedge clk);
    submit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stray_submit();
    gd3 = 4'd0; gd2 = 4'd0; gd1 = 4'd2;
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  localparam logic [3:0] HI  = 4'b1000;
  localparam logic [3:0] LO  = 4'b0100;
  localparam logic [3:0] OK  = 4'b0010;
  localparam logic [3:0] INV = 4'b0001;

  initial begin
    rst_n = 1'b0; start = 1'b0; submit = 1'b0;
    gd1 = 4'd0; gd2 = 4'd0; gd3 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_round", int'(round), 0);
    check("rst_maxd", int'(Max_digit), 0);
    check("rst_flags",
          int'({too_high, too_low, correct, invalid}), 0);
    check("rst_att", int'(attempts), 0);
    check("rst_wl", int'({win, lose, ready}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(ready), 0);

    // Start, then a submit landing in SETTLE must be lost
    do_start();
    @(negedge clk);
    gd3 = 4'd0; gd2 = 4'd0; gd1 = 4'd2;
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    check("settle_ready", int'(ready), 1);
    check("settle_flags",
          int'({too_high, too_low, correct, invalid}), 0);
    check("settle_att", int'(attempts), 0);
    check("r1_round", int'(round), 1);
    check("r1_maxd", int'(Max_digit), 1);

    // Round 1, target 002
    guess(0, 0, 5, ex(HI, 1, 2'b00), 1);
    guess(0, 0, 1, ex(LO, 2, 2'b00), 1);
    guess(0, 0, 2, ex(OK, 3, 2'b00), 1);
    @(negedge clk);
    check("load_correct", int'(correct), 1);
    check("load_round", int'(round), 1);
    @(negedge clk);
    check("r2_round", int'(round), 2);
    check("r2_maxd", int'(Max_digit), 1);
    check("r2_att", int'(attempts), 0);
    check("r2_correct", int'(correct), 0);

    // Rounds 2 and 3
    guess(0, 0, 5, ex(OK, 1, 2'b00), 1);
    guess(0, 0, 4'hA, ex(INV, 0, 2'b00), 1);
    @(negedge clk);
    check("inv_ready", int'(ready), 1);
    guess(0, 0, 9, ex(OK, 1, 2'b00), 1);

    // Round 4, target 057, two digits in play
    wait_ready("r4");
    check("r4_round", int'(round), 4);
    check("r4_maxd", int'(Max_digit), 2);
    guess(1, 0, 0, ex(INV, 0, 2'b00), 1);
    guess(0, 6, 0, ex(HI, 1, 2'b00), 1);
    guess(0, 5, 7, ex(OK, 2, 2'b00), 1);

    // Rounds 5 through 9
    guess(0, 1, 2, ex(OK, 1, 2'b00), 1);
    guess(0, 9, 9, ex(OK, 1, 2'b00), 1);
    wait_ready("r7");
    check("r7_maxd", int'(Max_digit), 3);
    guess(1, 2, 3, ex(OK, 1, 2'b00), 1);
    guess(4, 5, 5, ex(LO, 1, 2'b00), 1);
    guess(4, 5, 6, ex(OK, 2, 2'b00), 1);
    guess(9, 9, 8, ex(LO, 1, 2'b00), 1);
    guess(9, 9, 9, ex(OK, 2, 2'b10), 1);
    @(negedge clk);
    check("win_round", int'(round), 9);
    check("win_ready", int'(ready), 0);
    stray_submit();
    check("win_att_frozen", int'(attempts), 2);
    check("win_held", int'({win, lose}), 2);

    // Restart, then lose round 1 with five wrong guesses
    do_start();
    wait_ready("restart");
    check("rs_round", int'(round), 1);
    check("rs_wl", int'({win, lose}), 0);
    check("rs_att", int'(attempts), 0);
    for (int i = 1; i <= 5; i++)
      guess(0, 0, 4'(i + 2),
            ex(HI, 4'(i), (i == 5) ? 2'b01 : 2'b00), 1);
    @(negedge clk);
    stray_submit();
    check("lose_att", int'(attempts), 5);
    check("lose_held", int'({win, lose}), 1);
    check("lose_ready", int'(ready), 0);
    do_start();
    wait_ready("relose");
    check("rl_round", int'(round), 1);
    check("rl_lose", int'(lose), 0);
    check("rl_flags",
          int'({too_high, too_low, correct, invalid}), 0);

    // Reset while the guess is in COMPARE
    guess(0, 0, 2, ex(OK, 1, 2'b00), 0);
    rst_n = 1'b0;
    #1;
    check("mid_round", int'(round), 0);
    check("mid_maxd", int'(Max_digit), 0);
    check("mid_flags",
          int'({too_high, too_low, correct, invalid}), 0);
    check("mid_att", int'(attempts), 0);
    check("mid_ready", int'(ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'({ready, round}), 0);

    check("sb_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
